// File: rtl/camera_cfg_pkg.sv
`default_nettype none
// ============================================================================
// camera_cfg_pkg : shared types and constants for the camera config sequencer
// Revision: 1.0
// ============================================================================
package camera_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_WAIT_ROM  = 4'd2,
    ST_DECODE    = 4'd3,
    ST_ISSUE     = 4'd4,
    ST_WAIT_DONE = 4'd5,
    ST_DELAY     = 4'd6,
    ST_ADVANCE   = 4'd7,
    ST_FINISH    = 4'd8,
    ST_FAIL      = 4'd9
  } state_t;

  // Data-field tag that, together with an all-ones address, marks a delay entry
  localparam logic [7:0] c_delay_tag = 8'hF0;

endpackage : camera_cfg_pkg
`default_nettype wire

// File: rtl/cfg_delay_counter.sv
`default_nettype none
// ============================================================================
// cfg_delay_counter : loadable down-counter timing DELAY table entries
// Revision: 1.0
// ============================================================================
module cfg_delay_counter #(
  parameter int DELAY_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int                 c_cnt_w = $clog2(DELAY_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_load  = c_cnt_w'(DELAY_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_load;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule : cfg_delay_counter
`default_nettype wire

// File: rtl/camera_config_sequencer.sv
`default_nettype none
// ============================================================================
// camera_config_sequencer : walks a register-init ROM and issues SCCB writes
// Revision: 1.0
// ============================================================================
module camera_config_sequencer
  import camera_cfg_pkg::*;
#(
  parameter int REG_AW       = 8,
  parameter int REG_DW       = 8,
  parameter int IDX_W        = 8,
  parameter int SEL_W        = 2,
  parameter logic [REG_AW+REG_DW-1:0] END_CODE   = {(REG_AW+REG_DW){1'b1}},
  parameter logic [REG_AW+REG_DW-1:0] DELAY_CODE = {{REG_AW{1'b1}}, REG_DW'(c_delay_tag)},
  parameter int DELAY_CYCLES = 2_500_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SEL_W-1:0]         table_sel,
  output logic [SEL_W+IDX_W-1:0]   rom_addr,
  input  logic [REG_AW+REG_DW-1:0] rom_dout,
  output logic                     cmd_valid,
  output logic [REG_AW-1:0]        cmd_reg_addr,
  output logic [REG_DW-1:0]        cmd_reg_data,
  input  logic                     cmd_ready,
  input  logic                     cmd_done,
  input  logic                     cmd_nack,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [IDX_W-1:0]         entry_idx
);

  localparam int               c_word_w   = REG_AW + REG_DW;
  localparam int               c_retry_w  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = '1;

  state_t                   r_state;
  state_t                   w_next;
  logic [SEL_W-1:0]         r_sel;
  logic [IDX_W-1:0]         r_idx;
  logic [c_retry_w-1:0]     r_retry;
  logic [SEL_W+IDX_W-1:0]   r_rom_addr;
  logic [REG_AW-1:0]        r_addr;
  logic [REG_DW-1:0]        r_data;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic                     w_is_end;
  logic                     w_is_delay;
  logic                     w_retry_ok;
  logic                     w_dly_load;
  logic                     w_dly_dec;
  logic                     w_dly_zero;

  assign w_is_end   = (rom_dout == END_CODE);
  assign w_is_delay = (rom_dout == DELAY_CODE);
  assign w_retry_ok = (r_retry < c_retry_w'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = ST_FETCH;
      ST_FETCH:     w_next = ST_WAIT_ROM;
      ST_WAIT_ROM:  w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_is_end)        w_next = ST_FINISH;
        else if (w_is_delay) w_next = ST_DELAY;
        else                 w_next = ST_ISSUE;
      end
      ST_ISSUE:     if (cmd_ready) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (cmd_done) begin
          if (!cmd_nack)       w_next = ST_ADVANCE;
          else if (w_retry_ok) w_next = ST_ISSUE;
          else                 w_next = ST_FAIL;
        end
      end
      ST_DELAY:     if (w_dly_zero) w_next = ST_ADVANCE;
      // Running off the end of a table without an END word is a clean finish
      ST_ADVANCE:   w_next = (r_idx == c_last_idx) ? ST_FINISH : ST_FETCH;
      ST_FINISH:    w_next = ST_IDLE;
      ST_FAIL:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid  = (r_state == ST_ISSUE);
    w_dly_load = (r_state == ST_DECODE) && !w_is_end && w_is_delay;
    w_dly_dec  = (r_state == ST_DELAY) && !w_dly_zero;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel      <= '0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_rom_addr <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sel   <= table_sel;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        ST_FETCH: r_rom_addr <= {r_sel, r_idx};
        ST_DECODE: begin
          if (!w_is_end && !w_is_delay) begin
            r_addr  <= rom_dout[c_word_w-1:REG_DW];
            r_data  <= rom_dout[REG_DW-1:0];
            r_retry <= '0;
          end
        end
        ST_WAIT_DONE: begin
          if (cmd_done && cmd_nack && w_retry_ok) r_retry <= r_retry + c_retry_w'(1);
        end
        ST_ADVANCE: begin
          if (r_idx != c_last_idx) r_idx <= r_idx + IDX_W'(1);
        end
        ST_FINISH: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        ST_FAIL: begin
          r_busy  <= 1'b0;
          r_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  cfg_delay_counter #(
    .DELAY_CYCLES (DELAY_CYCLES)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .load  (w_dly_load),
    .dec   (w_dly_dec),
    .zero  (w_dly_zero)
  );

  assign rom_addr     = r_rom_addr;
  assign cmd_reg_addr = r_addr;
  assign cmd_reg_data = r_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign entry_idx    = r_idx;

endmodule : camera_config_sequencer
`default_nettype wire

// File: tb/tb_camera_config_sequencer.sv
`default_nettype none
// ============================================================================
// tb_camera_config_sequencer : scoreboard bench with a ROM and SCCB responder
// Revision: 1.0
// ============================================================================
module tb_camera_config_sequencer;

  localparam int IW  = 2;
  localparam int SW  = 2;
  localparam int DLY = 20;
  // Done seen -> ADVANCE+FETCH/WAIT_ROM/DECODE of delay word, delay, same again, ISSUE
  localparam int GAP_EXP = 4 + DLY + 4 + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] table_sel = '0;
  logic [SW+IW-1:0] rom_addr;
  logic [15:0]   rom_dout;
  logic          cmd_valid;
  logic [7:0]    cmd_reg_addr;
  logic [7:0]    cmd_reg_data;
  logic          cmd_ready = 1'b1;
  logic          cmd_done = 1'b0;
  logic          cmd_nack = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [IW-1:0] entry_idx;

  logic [15:0] rom [0:15];
  logic [15:0] exp_q [$];
  int          done_cyc [$];
  int          rise_cyc [$];
  int          tests = 0;
  int          fails = 0;
  int          n_xfer = 0;
  int          nack_left = 0;
  int          cyc = 0;

  camera_config_sequencer #(
    .REG_AW(8), .REG_DW(8), .IDX_W(IW), .SEL_W(SW),
    .DELAY_CYCLES(DLY), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .table_sel(table_sel),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .cmd_valid(cmd_valid), .cmd_reg_addr(cmd_reg_addr), .cmd_reg_data(cmd_reg_data),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_nack(cmd_nack),
    .busy(busy), .done(done), .error(error), .entry_idx(entry_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_dout <= rom[rom_addr];
    cyc      <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, 32'({rom_addr, cmd_valid, cmd_reg_addr, cmd_reg_data, busy, done, error, entry_idx}), 32'd0);
  endtask

  // Scoreboard monitor: every accepted command must match the head of the queue
  initial begin : monitor
    logic [15:0] e;
    logic        prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cmd: got 0x%0h, want no command", {cmd_reg_addr, cmd_reg_data});
        end else begin
          e = exp_q.pop_front();
          chk("cmd_fields", 32'({cmd_reg_addr, cmd_reg_data}), 32'(e));
        end
      end
      if (cmd_done && !cmd_nack) done_cyc.push_back(cyc);
      if (cmd_valid && !prev_valid) rise_cyc.push_back(cyc);
      prev_valid = cmd_valid;
    end
  end

  // SCCB model: done 5 cycles after each transfer; NACKs only register 0x13
  initial begin : responder
    logic is13;
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready && !reset) begin
        is13 = (cmd_reg_addr == 8'h13);
        repeat (5) @(posedge clk);
        #1;
        cmd_done = 1'b1;
        cmd_nack = is13 && (nack_left > 0);
        if (cmd_nack) nack_left--;
        @(posedge clk);
        #1;
        cmd_done = 1'b0;
        cmd_nack = 1'b0;
      end
    end
  end

  task automatic run_table(input logic [SW-1:0] sel, input int budget);
    @(posedge clk); #1;
    start = 1'b1;
    table_sel = sel;
    @(posedge clk); #1;
    start = 1'b0;
    table_sel = ~sel;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && (done || error)) return;
    end
    tests++;
    fails++;
    $display("FAIL finish_timeout: got busy=%0b after %0d cycles, want finished", busy, budget);
  endtask

  task automatic check_end(input string name, input logic exp_done, input logic exp_err,
                           input logic [IW-1:0] exp_idx, input int exp_cmds, input int base);
    chk({name, "_status"}, 32'({busy, done, error}), 32'({1'b0, exp_done, exp_err}));
    chk({name, "_idx"}, 32'(entry_idx), 32'(exp_idx));
    chk({name, "_ncmd"}, 32'(n_xfer - base), 32'(exp_cmds));
    chk({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  base;
    logic ok;
    rom[0]  = 16'h1280; rom[1]  = 16'h1180; rom[2]  = 16'hFFFF; rom[3]  = 16'h0000;
    rom[4]  = 16'h1280; rom[5]  = 16'hFFF0; rom[6]  = 16'h40D0; rom[7]  = 16'hFFFF;
    rom[8]  = 16'h1180; rom[9]  = 16'h13E5; rom[10] = 16'hFFFF; rom[11] = 16'hFFFF;
    rom[12] = 16'h2101; rom[13] = 16'hFF12; rom[14] = 16'h2303; rom[15] = 16'h2404;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_values");
    @(posedge clk); #1;
    reset = 1'b0;

    // Two plain writes then END
    base = n_xfer;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1180);
    run_table(2'd0, 300);
    check_end("t0", 1'b1, 1'b0, 2'd2, 2, base);

    // Write, DELAY, write, END
    base = n_xfer;
    done_cyc.delete(); rise_cyc.delete();
    exp_q.push_back(16'h1280); exp_q.push_back(16'h40D0);
    run_table(2'd1, 300);
    check_end("t1", 1'b1, 1'b0, 2'd3, 2, base);
    if (done_cyc.size() >= 1 && rise_cyc.size() >= 2)
      chk("delay_gap", 32'(rise_cyc[1] - done_cyc[0]), 32'(GAP_EXP));
    else begin
      tests++; fails++;
      $display("FAIL delay_gap: got %0d dones %0d rises, want 1 and 2", done_cyc.size(), rise_cyc.size());
    end

    // Three NACKs then ACK: four identical transfers of 13/E5
    base = n_xfer;
    nack_left = 3;
    exp_q.push_back(16'h1180);
    repeat (4) exp_q.push_back(16'h13E5);
    run_table(2'd2, 400);
    check_end("retry_ok", 1'b1, 1'b0, 2'd2, 5, base);

    // Four NACKs exhaust the retries on index 1
    base = n_xfer;
    nack_left = 4;
    exp_q.push_back(16'h1180);
    repeat (4) exp_q.push_back(16'h13E5);
    run_table(2'd2, 400);
    repeat (30) @(negedge clk);
    check_end("retry_fail", 1'b0, 1'b1, 2'd1, 5, base);

    // Back-pressure, start while busy, then reset mid-sequence
    base = n_xfer;
    cmd_ready = 1'b0;
    ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    table_sel = 2'd0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      start = (c == 10);
      table_sel = (c == 10) ? 2'd3 : 2'd0;
      reset = (c == 30);
      @(negedge clk);
      if (c >= 5 && c <= 30 && !(cmd_valid && busy && {cmd_reg_addr, cmd_reg_data} == 16'h1280))
        ok = 1'b0;
      if (c == 31) chk_reset("reset_mid_seq");
      if (c == 50) chk("idle_after_reset", 32'({busy, cmd_valid, done}), 32'd0);
    end
    chk("hold_stable", 32'(ok), 32'd1);
    cmd_ready = 1'b1;
    chk("hold_ncmd", 32'(n_xfer - base), 32'd0);

    // Reset beats a simultaneous start
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    table_sel = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("reset_wins", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("reset_wins_idle", 32'({busy, cmd_valid}), 32'd0);

    // No END word: whole 4-entry table written, including an all-ones address
    base = n_xfer;
    exp_q.push_back(16'h2101); exp_q.push_back(16'hFF12);
    exp_q.push_back(16'h2303); exp_q.push_back(16'h2404);
    run_table(2'd3, 400);
    check_end("no_end", 1'b1, 1'b0, 2'd3, 4, base);

    // END at index 0: done four cycles after the start is taken
    base = n_xfer;
    rom[8] = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b1;
    table_sel = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("end0_not_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("end0_done", 32'({busy, done, error}), 32'b010);
    chk("end0_ncmd", 32'(n_xfer - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_camera_config_sequencer
`default_nettype wire
